// File: rtl/eng_seq_ctrl.sv
// rtl/eng_seq_ctrl.sv - encode job sequencer: soft-reset, run, count, drain and complete one engine job
module eng_seq_ctrl #(
   parameter int K_MAX     = 8,
   parameter int PKT_CNT_W = 16,
   parameter int SEL_W     = $clog2(K_MAX),
   parameter int KW        = $clog2(K_MAX) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 job_start,
   input  logic [KW-1:0]        job_k,
   input  logic [PKT_CNT_W-1:0] job_num_pkts,
   input  logic                 job_abort,
   output logic                 job_busy,
   output logic                 job_done,
   output logic                 job_err,
   input  logic                 data_used,
   input  logic                 eng_pl_empty,
   input  logic                 outbuf_eng_full,
   output logic                 cntrl_eng_calc_en,
   output logic                 eng_rstn,
   output logic                 ctrl_din_val_gate,
   output logic [SEL_W-1:0]     bm_col_sel,
   output logic [PKT_CNT_W-1:0] pkt_cnt,
   output logic [15:0]          stall_cnt
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR   = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4,
      S_ABRT  = 3'd5
   } state_t;

   state_t               state;
   state_t               next_state;
   logic [KW-1:0]        k_lat;
   logic [PKT_CNT_W-1:0] num_lat;
   logic                 start_ok;
   logic                 active;
   logic                 beat;
   logic                 last_beat;
   logic                 col_wrap;
   logic                 busy_d;
   logic                 done_d;
   logic                 err_d;
   logic                 rstn_d;
   logic                 gate_d;

   assign start_ok = job_start && (job_k != '0) && (job_k <= KW'(K_MAX)) && (job_num_pkts != '0);
   assign active   = (state == S_RUN) || (state == S_DRAIN);

   // Engine may advance only while a job is live and the outbuf has room.
   assign cntrl_eng_calc_en = active && !outbuf_eng_full;

   // A beat is counted only in RUN; an abort in the same cycle wins over the count.
   assign beat      = (state == S_RUN) && data_used && cntrl_eng_calc_en && !job_abort;
   assign last_beat = beat && ((pkt_cnt + PKT_CNT_W'(1)) == num_lat);
   assign col_wrap  = (KW'(bm_col_sel) == (k_lat - KW'(1)));

   // State register plus registered control outputs derived from the upcoming state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= S_IDLE;
         job_busy          <= 1'b0;
         job_done          <= 1'b0;
         job_err           <= 1'b0;
         eng_rstn          <= 1'b1;
         ctrl_din_val_gate <= 1'b0;
      end else begin
         state             <= next_state;
         job_busy          <= busy_d;
         job_done          <= done_d;
         job_err           <= err_d;
         eng_rstn          <= rstn_d;
         ctrl_din_val_gate <= gate_d;
      end
   end

   // Job field latch, packet/column counters and saturating stall counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         k_lat      <= '0;
         num_lat    <= '0;
         pkt_cnt    <= '0;
         bm_col_sel <= '0;
         stall_cnt  <= '0;
      end else if ((state == S_IDLE) && start_ok) begin
         k_lat      <= job_k;
         num_lat    <= job_num_pkts;
         pkt_cnt    <= '0;
         bm_col_sel <= '0;
         stall_cnt  <= '0;
      end else begin
         if (beat) begin
            pkt_cnt    <= pkt_cnt + PKT_CNT_W'(1);
            bm_col_sel <= col_wrap ? '0 : bm_col_sel + SEL_W'(1);
         end
         if (active && outbuf_eng_full && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
      end
   end

   // Next-state selection; abort overrides everything in CLR, RUN and DRAIN.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (start_ok) next_state = S_CLR;
         S_CLR:   next_state = job_abort ? S_ABRT : S_RUN;
         S_RUN: begin
            if (job_abort)      next_state = S_ABRT;
            else if (last_beat) next_state = S_DRAIN;
         end
         S_DRAIN: begin
            if (job_abort)         next_state = S_ABRT;
            else if (eng_pl_empty) next_state = S_DONE;
         end
         S_DONE:  next_state = S_IDLE;
         S_ABRT:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Next-cycle values of the registered outputs.
   always_comb begin
      busy_d = (next_state != S_IDLE);
      done_d = (next_state == S_DONE);
      err_d  = (state == S_IDLE) && job_start && !start_ok;
      rstn_d = !((next_state == S_CLR) || (next_state == S_ABRT));
      gate_d = (next_state == S_RUN);
   end

endmodule

// File: tb/tb_eng_seq_ctrl.sv
// tb/tb_eng_seq_ctrl.sv - directed self-checking bench for eng_seq_ctrl
module tb_eng_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_start;
    logic [3:0]  job_k;
    logic [15:0] job_num_pkts;
    logic        job_abort;
    logic        job_busy;
    logic        job_done;
    logic        job_err;
    logic        data_used;
    logic        eng_pl_empty;
    logic        outbuf_eng_full;
    logic        cntrl_eng_calc_en;
    logic        eng_rstn;
    logic        ctrl_din_val_gate;
    logic [2:0]  bm_col_sel;
    logic [15:0] pkt_cnt;
    logic [15:0] stall_cnt;

    int checks    = 0;
    int failures  = 0;
    int done_seen = 0;
    int err_seen  = 0;
    int rstn_low  = 0;
    int base_done;
    int base_err;
    int base_rstn;
    bit finished  = 1'b0;

    eng_seq_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .job_start         (job_start),
        .job_k             (job_k),
        .job_num_pkts      (job_num_pkts),
        .job_abort         (job_abort),
        .job_busy          (job_busy),
        .job_done          (job_done),
        .job_err           (job_err),
        .data_used         (data_used),
        .eng_pl_empty      (eng_pl_empty),
        .outbuf_eng_full   (outbuf_eng_full),
        .cntrl_eng_calc_en (cntrl_eng_calc_en),
        .eng_rstn          (eng_rstn),
        .ctrl_din_val_gate (ctrl_din_val_gate),
        .bm_col_sel        (bm_col_sel),
        .pkt_cnt           (pkt_cnt),
        .stall_cnt         (stall_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        done_seen <= done_seen + int'(job_done);
        err_seen  <= err_seen + int'(job_err);
        rstn_low  <= rstn_low + int'(!eng_rstn);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        #1;
        chk({tag, "_busy"},  job_busy,          1'b0);
        chk({tag, "_done"},  job_done,          1'b0);
        chk({tag, "_err"},   job_err,           1'b0);
        chk({tag, "_rstn"},  eng_rstn,          1'b1);
        chk({tag, "_calc"},  cntrl_eng_calc_en, 1'b0);
        chk({tag, "_gate"},  ctrl_din_val_gate, 1'b0);
        chk({tag, "_col"},   bm_col_sel,        3'd0);
        chk({tag, "_pkt"},   pkt_cnt,           16'd0);
        chk({tag, "_stall"}, stall_cnt,         16'd0);
    endtask

    initial begin
        #200000;
        if (!finished) begin
            checks++;
            failures++;
            $error("FAIL timeout waiting for test completion");
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        rst = 1'b1; job_start = 1'b0; job_k = 4'd0; job_num_pkts = 16'd0; job_abort = 1'b0;
        data_used = 1'b0; eng_pl_empty = 1'b0; outbuf_eng_full = 1'b0;
        @(negedge clk);
        tick();
        tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        job_start = 1'b1; job_k = 4'd4; job_num_pkts = 16'd8;
        base_done = done_seen;
        tick();
        chk("basic_clr_busy", job_busy, 1'b1);
        chk("basic_clr_rstn", eng_rstn, 1'b0);
        chk("basic_clr_gate", ctrl_din_val_gate, 1'b0);
        job_start = 1'b0; data_used = 1'b1;
        tick();
        chk("basic_run_gate", ctrl_din_val_gate, 1'b1);
        chk("basic_run_calc", cntrl_eng_calc_en, 1'b1);
        chk("basic_run_rstn", eng_rstn, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("basic_col", bm_col_sel, 3'(i % 4));
            chk("basic_pkt", pkt_cnt, 16'(i));
            tick();
        end
        chk("basic_drain_gate", ctrl_din_val_gate, 1'b0);
        chk("basic_drain_pkt", pkt_cnt, 16'd8);
        chk("basic_drain_col", bm_col_sel, 3'd0);
        tick();
        tick();
        chk("basic_drain_hold", pkt_cnt, 16'd8);
        chk("basic_drain_nodone", job_done, 1'b0);
        eng_pl_empty = 1'b1;
        tick();
        chk("basic_done", job_done, 1'b1);
        chk("basic_done_busy", job_busy, 1'b1);
        eng_pl_empty = 1'b0; data_used = 1'b0;
        tick();
        chk("basic_idle_done", job_done, 1'b0);
        chk("basic_idle_busy", job_busy, 1'b0);
        chk("basic_idle_pkt", pkt_cnt, 16'd8);
        chk("basic_done_count", done_seen - base_done, 1);

        job_start = 1'b1; job_k = 4'd3; job_num_pkts = 16'd6;
        tick();
        chk("bp_clr_stall", stall_cnt, 16'd0);
        job_start = 1'b0; data_used = 1'b1;
        tick();
        tick();
        tick();
        chk("bp_pre_pkt", pkt_cnt, 16'd2);
        outbuf_eng_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_calc_off", cntrl_eng_calc_en, 1'b0);
            chk("bp_pkt_hold", pkt_cnt, 16'd2);
            tick();
        end
        outbuf_eng_full = 1'b0;
        #1;
        chk("bp_calc_on", cntrl_eng_calc_en, 1'b1);
        chk("bp_stall_mid", stall_cnt, 16'd5);
        for (int i = 2; i < 6; i++) begin
            chk("bp_col", bm_col_sel, 3'(i % 3));
            chk("bp_pkt", pkt_cnt, 16'(i));
            tick();
        end
        chk("bp_drain_gate", ctrl_din_val_gate, 1'b0);
        chk("bp_drain_pkt", pkt_cnt, 16'd6);
        data_used = 1'b0; eng_pl_empty = 1'b1;
        tick();
        chk("bp_done", job_done, 1'b1);
        chk("bp_stall_done", stall_cnt, 16'd5);
        eng_pl_empty = 1'b0;
        tick();
        chk("bp_idle_busy", job_busy, 1'b0);

        base_err = err_seen; base_rstn = rstn_low;
        for (int i = 0; i < 3; i++) begin
            job_start    = 1'b1;
            job_k        = (i == 0) ? 4'd0 : (i == 1) ? 4'd9 : 4'd4;
            job_num_pkts = (i == 2) ? 16'd0 : 16'd5;
            tick();
            chk("ill_err", job_err, 1'b1);
            chk("ill_busy", job_busy, 1'b0);
            chk("ill_rstn", eng_rstn, 1'b1);
            job_start = 1'b0;
            tick();
            chk("ill_err_clear", job_err, 1'b0);
            chk("ill_busy_after", job_busy, 1'b0);
        end
        chk("ill_err_count", err_seen - base_err, 3);
        chk("ill_rstn_count", rstn_low - base_rstn, 0);

        job_start = 1'b1; job_k = 4'd2; job_num_pkts = 16'd10;
        tick();
        job_start = 1'b0; data_used = 1'b1;
        tick();
        tick(); tick(); tick(); tick();
        chk("abrt_pre_pkt", pkt_cnt, 16'd4);
        chk("abrt_pre_col", bm_col_sel, 3'd0);
        job_abort = 1'b1; data_used = 1'b0;
        base_done = done_seen; base_rstn = rstn_low;
        tick();
        chk("abrt_rstn", eng_rstn, 1'b0);
        chk("abrt_busy", job_busy, 1'b1);
        chk("abrt_gate", ctrl_din_val_gate, 1'b0);
        job_abort = 1'b0;
        tick();
        chk("abrt_idle_busy", job_busy, 1'b0);
        chk("abrt_idle_rstn", eng_rstn, 1'b1);
        chk("abrt_rstn_count", rstn_low - base_rstn, 1);
        chk("abrt_no_done", done_seen - base_done, 0);

        job_start = 1'b1; job_k = 4'd2; job_num_pkts = 16'd2;
        tick();
        chk("restart_busy", job_busy, 1'b1);
        chk("restart_rstn", eng_rstn, 1'b0);
        chk("restart_pkt", pkt_cnt, 16'd0);
        job_start = 1'b0; data_used = 1'b1;
        tick();
        tick();
        tick();
        chk("rst_drain_gate", ctrl_din_val_gate, 1'b0);
        chk("rst_drain_busy", job_busy, 1'b1);
        chk("rst_drain_pkt", pkt_cnt, 16'd2);
        base_done = done_seen;
        rst = 1'b1;
        tick();
        check_reset_values("midrst");
        rst = 1'b0; data_used = 1'b0;
        tick();
        chk("midrst_busy_after", job_busy, 1'b0);
        chk("midrst_no_done", done_seen - base_done, 0);

        job_start = 1'b1; job_k = 4'd1; job_num_pkts = 16'd1;
        base_err = err_seen;
        tick();
        job_start = 1'b0; data_used = 1'b1;
        tick();
        chk("edge_run_gate", ctrl_din_val_gate, 1'b1);
        chk("edge_run_col", bm_col_sel, 3'd0);
        job_start = 1'b1; job_k = 4'd4; job_num_pkts = 16'd5;
        tick();
        chk("edge_drain_gate", ctrl_din_val_gate, 1'b0);
        chk("edge_drain_pkt", pkt_cnt, 16'd1);
        chk("edge_drain_col", bm_col_sel, 3'd0);
        chk("edge_no_err", job_err, 1'b0);
        job_start = 1'b0; data_used = 1'b0; eng_pl_empty = 1'b1;
        base_done = done_seen;
        tick();
        chk("edge_done", job_done, 1'b1);
        eng_pl_empty = 1'b0;
        tick();
        chk("edge_idle_busy", job_busy, 1'b0);
        chk("edge_idle_pkt", pkt_cnt, 16'd1);
        tick();
        chk("edge_stay_idle", job_busy, 1'b0);
        chk("edge_done_count", done_seen - base_done, 1);
        chk("edge_err_count", err_seen - base_err, 0);

        finished = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
